// File: rtl/ppwm_ctrl.sv
// Period controller and program store for the programmable PWM channel.
// Latency: start_o/pwm_o/global_counter_o are registered (one edge); instr_o is a combinational read of pc_i.
// Backpressure: prog_ready_o drops while a RUN-time write waits for a period boundary; writes offered while low are dropped.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable_i            run request (low forces IDLE)
//   prescale_i          counter advances every prescale_i+1 cycles (latched per period)
//   prog_we_i/addr/data program write request; prog_ready_o = no write pending
//   pc_i -> instr_o     asynchronous instruction fetch
//   start_o             one-cycle period-start pulse
//   global_counter_o    current global counter
//   pwm_value_i -> pwm_o registered duty compare
module ppwm_ctrl #(
    parameter int COUNTER_WIDTH  = 8,
    parameter int INSTR_WIDTH    = 6,
    parameter int PC_WIDTH       = 4,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      prog_we_i,
    input  logic [PC_WIDTH-1:0]       prog_addr_i,
    input  logic [INSTR_WIDTH-1:0]    prog_data_i,
    output logic                      prog_ready_o,
    input  logic [PC_WIDTH-1:0]       pc_i,
    output logic [INSTR_WIDTH-1:0]    instr_o,
    output logic                      start_o,
    output logic [COUNTER_WIDTH-1:0]  global_counter_o,
    input  logic [COUNTER_WIDTH-1:0]  pwm_value_i,
    output logic                      pwm_o
);

    localparam int DEPTH = 2**PC_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [COUNTER_WIDTH-1:0]  gc_q, gc_d;
    logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      start_q, start_d;
    logic                      pwm_q, pwm_d;
    logic                      pend_q, pend_d;
    logic [PC_WIDTH-1:0]       pend_addr_q, pend_addr_d;
    logic [INSTR_WIDTH-1:0]    pend_data_q, pend_data_d;
    logic [INSTR_WIDTH-1:0]    mem_q [DEPTH];

    logic                      tick;
    logic                      boundary;
    logic                      leaving;
    logic                      accept;
    logic                      commit;
    logic                      mem_we;
    logic [PC_WIDTH-1:0]       mem_waddr;
    logic [INSTR_WIDTH-1:0]    mem_wdata;

    always_comb begin
        tick     = (pre_q == presc_q);
        boundary = (state_q == ST_RUN) && tick && (gc_q == '1);
        leaving  = (state_q == ST_RUN) && !enable_i;
        accept   = prog_we_i && !pend_q;
        // A pending write lands either at the period boundary or when RUN is left.
        commit   = pend_q && (boundary || leaving);

        state_d     = state_q;
        gc_d        = gc_q;
        pre_d       = pre_q;
        presc_d     = presc_q;
        start_d     = 1'b0;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        mem_we      = 1'b0;
        mem_waddr   = prog_addr_i;
        mem_wdata   = prog_data_i;

        case (state_q)
            ST_IDLE: begin
                gc_d  = '0;
                pre_d = '0;
                if (enable_i) begin
                    state_d = ST_RUN;
                    presc_d = prescale_i;
                    start_d = 1'b1;
                end
            end
            default: begin
                if (!enable_i) begin
                    // Disable wins over a coincident boundary: no start pulse.
                    state_d = ST_IDLE;
                    gc_d    = '0;
                    pre_d   = '0;
                end else begin
                    if (tick) begin
                        pre_d = '0;
                        gc_d  = gc_q + 1'b1;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                    if (boundary) begin
                        presc_d = prescale_i;
                        start_d = 1'b1;
                    end
                end
            end
        endcase

        if (commit) begin
            mem_we    = 1'b1;
            mem_waddr = pend_addr_q;
            mem_wdata = pend_data_q;
            pend_d    = 1'b0;
        end else if (accept && ((state_q == ST_IDLE) || leaving)) begin
            // Outside a running period there is nothing to protect: write through.
            mem_we = 1'b1;
        end

        if (accept && (state_q == ST_RUN) && enable_i) begin
            // Buffered until the next boundary, even if accepted on one.
            pend_d      = 1'b1;
            pend_addr_d = prog_addr_i;
            pend_data_d = prog_data_i;
        end

        // Compare uses the pre-edge counter; forced low when leaving RUN.
        pwm_d = (state_q == ST_RUN) && enable_i && (gc_q < pwm_value_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gc_q        <= '0;
            pre_q       <= '0;
            presc_q     <= '0;
            start_q     <= 1'b0;
            pwm_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            state_q     <= state_d;
            gc_q        <= gc_d;
            pre_q       <= pre_d;
            presc_q     <= presc_d;
            start_q     <= start_d;
            pwm_q       <= pwm_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign instr_o          = mem_q[pc_i];
    assign prog_ready_o     = !pend_q;
    assign start_o          = start_q;
    assign global_counter_o = gc_q;
    assign pwm_o            = pwm_q;

endmodule

// File: doc/ppwm_ctrl.md
# ppwm_ctrl

Period controller and program store for the programmable PWM channel. Generates the prescaled global counter and the one-cycle period-start pulse that launch the instruction executor. Serves the executor's instruction fetch from a small program memory. Stages program writes so a running program only changes at a period boundary, and registers the final PWM output compare.

## Interface
- COUNTER_WIDTH, 8: width of the global counter and PWM value.
- INSTR_WIDTH, 6: instruction word width.
- PC_WIDTH, 4: program address width; memory depth is 2**PC_WIDTH.
- PRESCALE_WIDTH, 4: width of the prescaler setting.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- enable_i  in  1  run request; low forces IDLE.
- prescale_i  in  PRESCALE_WIDTH  counter advances every prescale_i+1 cycles.
- prog_we_i  in  1  program write request.
- prog_addr_i  in  PC_WIDTH  write address.
- prog_data_i  in  INSTR_WIDTH  write data.
- prog_ready_o  out  1  write accepted when prog_we_i && prog_ready_o.
- pc_i  in  PC_WIDTH  fetch address from the executor.
- instr_o  out  INSTR_WIDTH  instruction at pc_i.
- start_o  out  1  one-cycle period-start pulse.
- global_counter_o  out  COUNTER_WIDTH  current global counter.
- pwm_value_i  in  COUNTER_WIDTH  duty value from the executor.
- pwm_o  out  1  registered PWM output.

## Operation
- States:
  - IDLE: counter held at 0.
  - RUN: counter and prescaler active.
- IDLE->RUN when enable_i=1. RUN->IDLE when enable_i=0, effective at the next edge with no period completion.
- Prescaler pre_q counts 0..presc_q. A tick occurs when pre_q==presc_q; on a tick pre_q<=0 and gc<=gc+1, modulo 2**COUNTER_WIDTH.
- presc_q is loaded from prescale_i on IDLE->RUN entry and at every period boundary. It is stable within a period.
- A period boundary is a tick with gc==all-ones: gc wraps to 0.
- start_o is asserted for one cycle on:
  - the first RUN cycle;
  - the cycle after each boundary edge.
- Program memory: 2**PC_WIDTH x INSTR_WIDTH, cleared to 0 (NOP) on reset. instr_o = mem[pc_i] is an asynchronous read.
- Writes in IDLE go directly to memory at the accepting edge.
- Writes in RUN are captured in a one-entry buffer; pending=1 and prog_ready_o=0. The buffer commits to memory:
  - at the next boundary edge; or
  - at the edge leaving RUN.
- A write accepted on a boundary edge waits for the following boundary.
- A read of an address with a pending write returns the old data until commit.
- prog_we_i while prog_ready_o=0 is ignored and not queued.
- prog_ready_o = !pending.
- pwm_o <= (state==RUN) && (gc < pwm_value_i): one-cycle latency, compared against the pre-edge gc.
- Prescale 0 is valid (tick every cycle). The maximum prescale is 2**PRESCALE_WIDTH-1.

## Timing
- Reset values: state IDLE, gc=0, pre_q=0, presc_q=0, start_o=0, pwm_o=0, prog_ready_o=1, pending=0, memory all 0.
- Reset asserted mid-period or with a write pending: the pending write is discarded and all of the above apply on the next edge.
- Startup: enable_i sampled 1 in IDLE at edge N. From N, state=RUN, gc=0, pre_q=0, start_o=1 for one cycle. The first tick is presc_q cycles later.
- Period length in RUN: 2**COUNTER_WIDTH x (presc_q+1) cycles; start_o pulses are exactly that far apart.
- Disable: enable_i sampled 0 at edge M.
  - From M: state IDLE, gc=0, pre_q=0, pwm_o=0, start_o=0.
  - Any pending write is committed at M.
- Boundary edge coincident with enable_i=0: IDLE wins and start_o stays 0.
- prog_ready_o falls the cycle after a RUN write is accepted, and rises the cycle after the commit edge.

## Test plan
- Reset, enable with prescale_i=0 -> start_o pulses on the first RUN cycle and every 256 cycles after. gc reads 0,1,...,255,0.
- prescale_i=3 -> gc increments every 4 cycles, period 1024 cycles. Changing prescale_i to 0 mid-period -> no effect until the next start_o.
- IDLE write addr 5 = 6'h2A -> with pc_i=5, instr_o=6'h2A on the next cycle.
- RUN write addr 3 = 6'h11 at gc=10:
  - prog_ready_o=0;
  - instr_o at pc_i=3 keeps its old value until the boundary, then reads 6'h11;
  - a second write attempted while not ready is dropped.
- pwm_value_i=64, prescale 0 -> pwm_o high for exactly 64 cycles per 256-cycle period, delayed one cycle from gc. pwm_value_i=0 -> pwm_o never high.
- enable_i dropped at gc=100 with a write pending -> IDLE, gc=0, pwm_o=0 next cycle, write committed, prog_ready_o=1. Re-enable -> immediate start_o pulse.
